// File: rtl/dlx_pkg.sv
// dlx_pkg: definitions shared by the DLX fetch unit and the control block.
//   fetch_state_e : fetch FSM encodings (FETCH / ISSUE / HALT)
//   PC_INC        : sequential PC increment (one 32-bit word)
//   OFF16_MSB     : top bit of the branch offset field (beqz/bnez)
//   OFF26_MSB     : top bit of the jump offset field (j/jal)
//   sext16/sext26 : sign-extend the offset fields to 32 bits
package dlx_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_ISSUE = 2'b01,
    ST_HALT  = 2'b10
  } fetch_state_e;

  localparam logic [31:0] PC_INC    = 32'd4;
  localparam int          OFF16_MSB = 15;
  localparam int          OFF26_MSB = 25;

  function automatic logic [31:0] sext16(input logic [OFF16_MSB:0] off);
    return {{(31 - OFF16_MSB){off[OFF16_MSB]}}, off};
  endfunction

  function automatic logic [31:0] sext26(input logic [OFF26_MSB:0] off);
    return {{(31 - OFF26_MSB){off[OFF26_MSB]}}, off};
  endfunction

endpackage

// File: rtl/dlx_next_pc.sv
// dlx_next_pc: combinational next-PC selection for the fetch unit.
//   pc           in  32  PC of the instruction being consumed
//   off26        in  26  instruction[25:0] (branch offset is its low 16 bits)
//   branch_taken in  1   beqz/bnez condition true
//   jump         in  1   j/jal
//   jump_reg     in  1   jr/jalr
//   jr_target    in  32  register target for jump_reg
//   next_pc      out 32  unaligned next PC; alignment handling is the caller's
// Priority: jump_reg > jump > branch_taken > sequential. All adds wrap at 32 bits.
module dlx_next_pc
  import dlx_pkg::*;
(
  input  logic [31:0]        pc,
  input  logic [OFF26_MSB:0] off26,
  input  logic               branch_taken,
  input  logic               jump,
  input  logic               jump_reg,
  input  logic [31:0]        jr_target,
  output logic [31:0]        next_pc
);

  logic [31:0] pc4;

  assign pc4 = pc + PC_INC;

  always_comb begin
    next_pc = pc4;
    if (jump_reg)          next_pc = jr_target;
    else if (jump)         next_pc = pc4 + sext26(off26);
    else if (branch_taken) next_pc = pc4 + sext16(off26[OFF16_MSB:0]);
  end

endmodule

// File: rtl/dlx_fetch_unit.sv
// dlx_fetch_unit: DLX instruction fetch stage.
//   Holds the PC, fetches words from a variable-latency imem and presents
//   one instruction at a time to execute on a valid/ready handshake.
// Ports:
//   clk, reset (async, active high)
//   imem_req/imem_addr/imem_ack/imem_rdata : instruction memory request side
//   instruction/instr_valid/instr_ready/pc_out : handshake towards execute
//   branch_taken/jump/jump_reg/jr_target : resolution from execute, used
//     only in the cycle an instruction is consumed
//   fetch_fault : sticky fault (imem timeout, or misaligned target)
// Parameters: RESET_PC, IMEM_TIMEOUT (1..255 cycles of waiting for ack).
// Build option: DLX_FETCH_ALIGN_CHK_EN -- when defined, a misaligned next PC
//   at consume raises fetch_fault and halts with the bad PC left on pc_out;
//   when undefined the low two PC bits are simply cleared.
module dlx_fetch_unit
  import dlx_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc_out,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [31:0] jr_target,
  output logic        fetch_fault
);

  localparam logic [7:0] TMO_LAST = 8'(IMEM_TIMEOUT - 1);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         req_q, req_d;
  logic         fault_q, fault_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [31:0]  npc;

  dlx_next_pc u_next_pc (
    .pc           (pc_q),
    .off26        (instr_q[OFF26_MSB:0]),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jump_reg     (jump_reg),
    .jr_target    (jr_target),
    .next_pc      (npc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= 8'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    req_d   = req_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_FETCH: begin
        req_d = 1'b1;
        // Ack/timeout only count once the request is actually on the bus;
        // this also drops an ack left over from before a reset.
        if (req_q) begin
          if (imem_ack) begin
            instr_d = imem_rdata;
            valid_d = 1'b1;
            req_d   = 1'b0;
            cnt_d   = 8'h0;
            state_d = ST_ISSUE;
          end else if (cnt_q == TMO_LAST) begin
            fault_d = 1'b1;
            req_d   = 1'b0;
            state_d = ST_HALT;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_ISSUE: begin
        if (instr_ready) begin
          valid_d = 1'b0;
`ifdef DLX_FETCH_ALIGN_CHK_EN
          // Keep the bad target in pc so it is visible on pc_out.
          pc_d = npc;
          if (npc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end else begin
            req_d   = 1'b1;
            state_d = ST_FETCH;
          end
`else
          pc_d    = npc & ~32'h3;
          req_d   = 1'b1;
          state_d = ST_FETCH;
`endif
        end
      end
      ST_HALT: begin
        req_d = 1'b0;
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_HALT;
      end
    endcase
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc_out      = pc_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_dlx_fetch_unit.sv
module tb_dlx_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TMO      = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'h0;
  logic [31:0] instruction, pc_out, jr_target = 32'h0;
  logic        instr_valid, instr_ready = 1'b0;
  logic        branch_taken = 1'b0, jump = 1'b0, jump_reg = 1'b0;
  logic        fetch_fault;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dlx_fetch_unit #(.RESET_PC(RESET_PC), .IMEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc_out(pc_out),
    .branch_taken(branch_taken), .jump(jump), .jump_reg(jump_reg),
    .jr_target(jr_target), .fetch_fault(fetch_fault)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // All stimulus tasks start and end on a falling edge.
  task automatic clr_ctrl;
    instr_ready = 0; branch_taken = 0; jump = 0; jump_reg = 0; jr_target = 0;
  endtask

  task automatic do_reset;
    reset = 1; imem_ack = 0; clr_ctrl();
    @(negedge clk); @(negedge clk);
    reset = 0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (imem_req === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  // Serve one fetch after lat extra cycles; addr reports the requested
  // address (x if no request showed up within the bound).
  task automatic fetch(input logic [31:0] data, input int lat, output logic [31:0] addr);
    bit ok;
    wait_req(ok);
    addr = ok ? imem_addr : 32'hx;
    repeat (lat) @(negedge clk);
    imem_ack = 1; imem_rdata = data;
    @(negedge clk);
    imem_ack = 0; imem_rdata = $urandom;
  endtask

  task automatic consume(input bit jr, input bit j, input bit br, input logic [31:0] tgt);
    instr_ready = 1; jump_reg = jr; jump = j; branch_taken = br; jr_target = tgt;
    @(negedge clk);
    clr_ctrl();
  endtask

  task automatic test_reset;
    reset = 1; imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 0 || instr_valid !== 0 || instruction !== 32'h0 ||
        fetch_fault !== 0 || pc_out !== RESET_PC || imem_addr !== RESET_PC) begin
      n_bad++;
      $display("FAIL reset_state: req=%b vld=%b instr=%h fault=%b pc=%h addr=%h, want 0 0 0 0 %h %h",
               imem_req, instr_valid, instruction, fetch_fault, pc_out, imem_addr, RESET_PC, RESET_PC);
    end
    imem_ack = 0;
    reset = 0;
  endtask

  task automatic test_basic;
    logic [31:0] a;
    do_reset();
    fetch(32'h00A41024, 2, a);
    n_cmp++;
    if (a !== 32'h0) begin n_bad++; $display("FAIL basic_addr: got %h want 00000000", a); end
    n_cmp++;
    if (instr_valid !== 1 || instruction !== 32'h00A41024 || pc_out !== 32'h0 || imem_req !== 0) begin
      n_bad++;
      $display("FAIL basic_present: vld=%b instr=%h pc=%h req=%b, want 1 00a41024 0 0",
               instr_valid, instruction, pc_out, imem_req);
    end
    for (int i = 0; i < 10; i++) begin
      instr_ready = 0;
      branch_taken = 1'($urandom); jump = 1'($urandom); jump_reg = 1'($urandom);
      jr_target = $urandom;
      @(negedge clk);
      n_cmp++;
      if (instr_valid !== 1 || instruction !== 32'h00A41024 || pc_out !== 32'h0 || imem_req !== 0) begin
        n_bad++;
        $display("FAIL basic_hold[%0d]: vld=%b instr=%h pc=%h req=%b, want 1 00a41024 0 0",
                 i, instr_valid, instruction, pc_out, imem_req);
      end
    end
    clr_ctrl();
    consume(0, 0, 0, 32'h0);
    n_cmp++;
    if (imem_req !== 1 || imem_addr !== 32'h4 || instr_valid !== 0) begin
      n_bad++;
      $display("FAIL basic_next: req=%b addr=%h vld=%b, want 1 00000004 0", imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_branch_jump;
    logic [31:0] a;
    fetch(32'h0, 0, a);
    consume(1, 0, 0, 32'h100);
    fetch(32'h1420FFF8, 1, a);
    n_cmp++;
    if (a !== 32'h100) begin n_bad++; $display("FAIL jr_addr: got %h want 00000100", a); end
    consume(0, 0, 1, 32'h0);
    fetch(32'h0, 0, a);
    n_cmp++;
    if (a !== 32'h0FC) begin n_bad++; $display("FAIL branch_back: got %h want 000000fc", a); end
    consume(1, 0, 0, 32'h200);
    fetch(32'h08000010, 3, a);
    consume(0, 1, 0, 32'h0);
    fetch(32'h0000FFF0, 0, a);
    n_cmp++;
    if (a !== 32'h214) begin n_bad++; $display("FAIL jump_fwd: got %h want 00000214", a); end
    // jump_reg outranks jump and branch
    consume(1, 1, 1, 32'h400);
    fetch(32'h0, 0, a);
    n_cmp++;
    if (a !== 32'h400) begin n_bad++; $display("FAIL jr_priority: got %h want 00000400", a); end
  endtask

  task automatic test_wrap;
    logic [31:0] a;
    consume(1, 0, 0, 32'hFFFF_FFFC);
    fetch(32'h0, 0, a);
    n_cmp++;
    if (a !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_top: got %h want fffffffc", a); end
    consume(0, 0, 0, 32'h0);
    fetch(32'h0, 0, a);
    n_cmp++;
    if (a !== 32'h0) begin n_bad++; $display("FAIL wrap_zero: got %h want 00000000", a); end
    consume(0, 0, 0, 32'h0);
  endtask

  task automatic test_timeout;
    bit ok;
    do_reset();
    wait_req(ok);
    for (int i = 1; i <= TMO; i++) begin
      if (i == TMO) begin
        n_cmp++;
        if (!ok || imem_req !== 1 || fetch_fault !== 0) begin
          n_bad++;
          $display("FAIL tmo_edge: req=%b fault=%b at wait cycle %0d, want 1 0", imem_req, fetch_fault, i);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (imem_req !== 0 || fetch_fault !== 1) begin
      n_bad++;
      $display("FAIL tmo_fault: req=%b fault=%b, want 0 1", imem_req, fetch_fault);
    end
    for (int i = 0; i < 5; i++) begin
      imem_ack = 1; imem_rdata = $urandom; instr_ready = 1;
      @(negedge clk);
    end
    imem_ack = 0; clr_ctrl();
    n_cmp++;
    if (imem_req !== 0 || fetch_fault !== 1 || instr_valid !== 0) begin
      n_bad++;
      $display("FAIL tmo_sticky: req=%b fault=%b vld=%b, want 0 1 0", imem_req, fetch_fault, instr_valid);
    end
    // ack on the last allowed cycle is a normal fetch
    begin
      logic [31:0] a;
      do_reset();
      fetch(32'hCAFE_0004, TMO - 1, a);
      n_cmp++;
      if (fetch_fault !== 0 || instr_valid !== 1 || instruction !== 32'hCAFE_0004 || a !== RESET_PC) begin
        n_bad++;
        $display("FAIL tmo_ack_wins: fault=%b vld=%b instr=%h addr=%h, want 0 1 cafe0004 %h",
                 fetch_fault, instr_valid, instruction, a, RESET_PC);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] a;
    consume(0, 0, 0, 32'h0);
    repeat (2) @(negedge clk);
    imem_ack = 1; imem_rdata = 32'h1234_5678; reset = 1;
    @(negedge clk);
    reset = 0;                       // ack stays high one cycle past reset
    @(negedge clk);
    imem_ack = 0;
    n_cmp++;
    if (instr_valid !== 0 || pc_out !== RESET_PC || imem_addr !== RESET_PC ||
        instruction !== 32'h0 || imem_req !== 1) begin
      n_bad++;
      $display("FAIL reset_mid: vld=%b pc=%h addr=%h instr=%h req=%b, want 0 %h %h 0 1",
               instr_valid, pc_out, imem_addr, instruction, imem_req, RESET_PC, RESET_PC);
    end
    fetch(32'h0BAD_F00C, 1, a);
    n_cmp++;
    if (a !== RESET_PC || instruction !== 32'h0BAD_F00C || instr_valid !== 1) begin
      n_bad++;
      $display("FAIL reset_mid_refetch: addr=%h instr=%h vld=%b, want %h 0badf00c 1",
               a, instruction, instr_valid, RESET_PC);
    end
  endtask

  // Random traffic against a model of the PC sequence.
  task automatic test_random;
    logic [31:0] mpc, data, tgt, nxt, p4;
    bit ok, jr, j, br;
    int lat, hold;
    do_reset();
    mpc = RESET_PC;
    for (int t = 0; t < 60; t++) begin
      data = $urandom & ~32'h3;      // keeps branch/jump targets aligned
      lat  = $urandom_range(0, 6);
      hold = $urandom_range(0, 3);
      wait_req(ok);
      n_cmp++;
      if (!ok || imem_addr !== mpc) begin
        n_bad++;
        $display("FAIL rnd_addr[%0d]: ok=%b addr=%h want %h", t, ok, imem_addr, mpc);
      end
      for (int c = 0; c < lat; c++) begin
        instr_ready = 1'($urandom); jump_reg = 1'($urandom); jump = 1'($urandom);
        branch_taken = 1'($urandom); jr_target = $urandom;
        @(negedge clk);
      end
      imem_ack = 1; imem_rdata = data; instr_ready = 1'($urandom);
      @(negedge clk);
      imem_ack = 0;
      n_cmp++;
      if (instr_valid !== 1 || instruction !== data || pc_out !== mpc) begin
        n_bad++;
        $display("FAIL rnd_present[%0d]: vld=%b instr=%h pc=%h want 1 %h %h",
                 t, instr_valid, instruction, pc_out, data, mpc);
      end
      for (int c = 0; c < hold; c++) begin
        instr_ready = 0; jump_reg = 1'($urandom); jump = 1'($urandom);
        branch_taken = 1'($urandom); jr_target = $urandom;
        @(negedge clk);
      end
      jr = ($urandom_range(0, 3) == 0);
      j  = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 2) == 0);
      tgt = $urandom & ~32'h3;
      p4 = mpc + 32'd4;
      if (jr)      nxt = tgt;
      else if (j)  nxt = p4 + 32'($signed(data[25:0]));
      else if (br) nxt = p4 + 32'($signed(data[15:0]));
      else         nxt = p4;
      consume(jr, j, br, tgt);
      mpc = nxt;
    end
  endtask

  task automatic test_align;
    logic [31:0] a;
    fetch(32'h0, 0, a);
    consume(1, 0, 0, 32'h402);
`ifdef DLX_FETCH_ALIGN_CHK_EN
    repeat (3) @(negedge clk);
    n_cmp++;
    if (fetch_fault !== 1 || pc_out !== 32'h402 || imem_req !== 0) begin
      n_bad++;
      $display("FAIL align_fault: fault=%b pc=%h req=%b, want 1 00000402 0", fetch_fault, pc_out, imem_req);
    end
`else
    fetch(32'h0, 0, a);
    n_cmp++;
    if (a !== 32'h400 || fetch_fault !== 0) begin
      n_bad++;
      $display("FAIL align_force: addr=%h fault=%b, want 00000400 0", a, fetch_fault);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_branch_jump();
    test_wrap();
    test_timeout();
    test_reset_mid();
    test_random();
    test_align();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
